pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard, stall and forwarding controller for the pipelined CPU.
- Replaces the separate hazard-detection unit, forwarding unit and flush logic with one sequential block.
- Generalised to FWD_STAGES forwarding sources, a configurable load-use latency, ID-stage branch-compare hazards and data-memory wait states.
- Sits beside the IF/ID and ID/EX registers; drives PC write, IF/ID write/flush, the ID/EX control bubble, the pipeline hold and the EX operand mux selects.

---
 rtl/pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: combined hazard detection, stall sequencing, ID-stage
// flush and EX operand forwarding for the pipelined CPU.
//
// Handshake: the block has no valid/ready pair. The pipeline obeys the
// control outputs on every clock edge. pipe_hold_o freezes the back-end
// registers. pc_write_o and ifid_write_o gate the front end.
// idex_bubble_o zeroes the control fields entering ID/EX.
//
// Optional build macro HAZ_STALL_CNT_EN adds stall_cnt_o. This is a
// saturating count of cycles in which the PC was held.
//
// state_o exposes the controller state register: 0 RUN, 1 STALL, 2 MEMWAIT.
module pipe_hazard_ctrl #(
    parameter int  AW         = 5,
    parameter int  FWD_STAGES = 2,
    parameter int  LOAD_LAT   = 1,
    localparam int SW         = $clog2(FWD_STAGES + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [AW-1:0]            id_rs_i,
    input  logic [AW-1:0]            id_rt_i,
    input  logic                     id_rs_use_i,
    input  logic                     id_rt_use_i,
    input  logic                     id_branch_i,
    input  logic                     id_taken_i,
    input  logic                     id_jump_i,
    input  logic [AW-1:0]            ex_rd_i,
    input  logic                     ex_regwrite_i,
    input  logic                     ex_memread_i,
    input  logic [AW-1:0]            ex_rs_i,
    input  logic [AW-1:0]            ex_rt_i,
    input  logic [FWD_STAGES*AW-1:0] fwd_rd_i,
    input  logic [FWD_STAGES-1:0]    fwd_we_i,
    input  logic                     mem_busy_i,
    output logic [SW-1:0]            fwd_a_o,
    output logic [SW-1:0]            fwd_b_o,
    output logic                     pc_write_o,
    output logic                     ifid_write_o,
    output logic                     ifid_flush_o,
    output logic                     idex_bubble_o,
    output logic                     pipe_hold_o,
`ifdef HAZ_STALL_CNT_EN
    output logic [1:0]               state_o,
    output logic [31:0]              stall_cnt_o
`else
    output logic [1:0]               state_o
`endif
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] STALL   = 2'd1;
    localparam logic [1:0] MEMWAIT = 2'd2;

    // Wide enough for LOAD_LAT up to 7. A branch waiting on a load counts LOAD_LAT.
    localparam int CW = 3;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [1:0]    saved;
    logic [1:0]    saved_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    logic [SW-1:0] sel_a;
    logic [SW-1:0] sel_b;

    logic          src_hit;
    logic          lu;
    logic          bc;
    logic [CW-1:0] lu_cnt;
    logic [1:0]    cur;

    logic          stall;
    logic          hold;
    logic          flush_req;

    // Operand A forward select: the youngest stage writing ex_rs_i wins. $0 never forwards.
    always_comb begin
        sel_a = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (fwd_we_i[k] && (fwd_rd_i[k*AW +: AW] == ex_rs_i) && (ex_rs_i != '0)) begin
                sel_a = SW'(k + 1);
            end
        end
    end

    // Operand B forward select: same rule as operand A, applied to ex_rt_i.
    always_comb begin
        sel_b = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (fwd_we_i[k] && (fwd_rd_i[k*AW +: AW] == ex_rt_i) && (ex_rt_i != '0)) begin
                sel_b = SW'(k + 1);
            end
        end
    end

    // Hazard terms. They compare the ID/EX destination against the sources the ID instruction actually reads.
    always_comb begin
        src_hit = (id_rs_use_i && (ex_rd_i == id_rs_i)) ||
                  (id_rt_use_i && (ex_rd_i == id_rt_i));
        lu      = ex_memread_i && (ex_rd_i != '0) && src_hit;
        bc      = id_branch_i && ex_regwrite_i && !ex_memread_i &&
                  (ex_rd_i != '0) && src_hit;
        // A branch that compares in ID needs the load to reach WB, so it stalls one extra cycle.
        lu_cnt  = id_branch_i ? CW'(LOAD_LAT) : CW'(LOAD_LAT - 1);
        // Leaving MEMWAIT resumes the interrupted state in the same cycle.
        cur     = (state == MEMWAIT) ? saved : state;
    end

    // Next-state and control decode. Priority: memory wait, load-use, branch-compare, flush.
    always_comb begin
        state_nx  = state;
        saved_nx  = saved;
        cnt_nx    = cnt;
        stall     = 1'b0;
        hold      = 1'b0;
        flush_req = 1'b0;
        if (mem_busy_i) begin
            hold     = 1'b1;
            state_nx = MEMWAIT;
            if (state != MEMWAIT) begin
                saved_nx = state;
            end
        end else begin
            case (cur)
                STALL: begin
                    stall    = 1'b1;
                    cnt_nx   = (cnt == '0) ? '0 : cnt - CW'(1);
                    state_nx = (cnt <= CW'(1)) ? RUN : STALL;
                end
                default: begin
                    state_nx = RUN;
                    if (lu) begin
                        stall    = 1'b1;
                        cnt_nx   = lu_cnt;
                        state_nx = (lu_cnt != '0) ? STALL : RUN;
                    end else if (bc) begin
                        stall = 1'b1;
                    end else begin
                        flush_req = id_jump_i || (id_branch_i && id_taken_i);
                    end
                end
            endcase
        end
    end

    // State, saved state and stall counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
            saved <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            saved <= saved_nx;
            cnt   <= cnt_nx;
        end
    end

    // Output drive. While reset is low the outputs take their reset values immediately.
    always_comb begin
        fwd_a_o       = rst_i ? sel_a : '0;
        fwd_b_o       = rst_i ? sel_b : '0;
        pc_write_o    = !rst_i || !(stall || hold);
        ifid_write_o  = !rst_i || !(stall || hold);
        ifid_flush_o  = rst_i && flush_req;
        idex_bubble_o = rst_i && stall;
        pipe_hold_o   = rst_i && hold;
        state_o       = rst_i ? state : RUN;
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (!pc_write_o && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances run on the same stimulus:
// one has LOAD_LAT=1 and the other LOAD_LAT=3. A cycle-level reference
// model counts the remaining stall cycles and predicts every output.
// A separate monitor compares each instance against its expected queue.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int FS = 2;
    localparam int W  = 43;

    logic clk = 1'b0;
    logic rst;

    logic [AW-1:0]    id_rs, id_rt, ex_rd, ex_rs, ex_rt;
    logic             id_rs_use, id_rt_use, id_branch, id_taken, id_jump;
    logic             ex_regwrite, ex_memread, mem_busy;
    logic [FS*AW-1:0] fwd_rd;
    logic [FS-1:0]    fwd_we;

    logic [1:0]  fwd_a [2];
    logic [1:0]  fwd_b [2];
    logic [1:0]  state [2];
    logic        pc_write [2];
    logic        ifid_write [2];
    logic        ifid_flush [2];
    logic        idex_bubble [2];
    logic        pipe_hold [2];
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt [2];
`endif

    // Clock and watchdog.
    initial forever #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    pipe_hazard_ctrl #(.AW(AW), .FWD_STAGES(FS), .LOAD_LAT(1)) u_l1 (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_use_i(id_rs_use), .id_rt_use_i(id_rt_use),
        .id_branch_i(id_branch), .id_taken_i(id_taken), .id_jump_i(id_jump),
        .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .fwd_rd_i(fwd_rd), .fwd_we_i(fwd_we),
        .mem_busy_i(mem_busy),
        .fwd_a_o(fwd_a[0]), .fwd_b_o(fwd_b[0]), .pc_write_o(pc_write[0]),
        .ifid_write_o(ifid_write[0]), .ifid_flush_o(ifid_flush[0]),
        .idex_bubble_o(idex_bubble[0]), .pipe_hold_o(pipe_hold[0]),
`ifdef HAZ_STALL_CNT_EN
        .state_o(state[0]), .stall_cnt_o(stall_cnt[0])
`else
        .state_o(state[0])
`endif
    );

    pipe_hazard_ctrl #(.AW(AW), .FWD_STAGES(FS), .LOAD_LAT(3)) u_l3 (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_use_i(id_rs_use), .id_rt_use_i(id_rt_use),
        .id_branch_i(id_branch), .id_taken_i(id_taken), .id_jump_i(id_jump),
        .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .fwd_rd_i(fwd_rd), .fwd_we_i(fwd_we),
        .mem_busy_i(mem_busy),
        .fwd_a_o(fwd_a[1]), .fwd_b_o(fwd_b[1]), .pc_write_o(pc_write[1]),
        .ifid_write_o(ifid_write[1]), .ifid_flush_o(ifid_flush[1]),
        .idex_bubble_o(idex_bubble[1]), .pipe_hold_o(pipe_hold[1]),
`ifdef HAZ_STALL_CNT_EN
        .state_o(state[1]), .stall_cnt_o(stall_cnt[1])
`else
        .state_o(state[1])
`endif
    );

    // Reference model state: remaining stall cycles, whether the last cycle was a memory wait,
    // and the number of PC-held cycles so far.
    int          stall_left [2];
    bit          busy_prev [2];
    logic [31:0] held_cycles [2];

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Forward select: the first (youngest) stage that writes a nonzero register r.
    function automatic logic [1:0] fsel(input logic [AW-1:0] r);
        logic [1:0] s;
        s = 2'd0;
        if (r != '0) begin
            for (int k = 0; k < FS; k++) begin
                if (s == 2'd0 && fwd_we[k] && fwd_rd[k*AW +: AW] == r) s = 2'(k + 1);
            end
        end
        return s;
    endfunction

    task automatic model_step(input int d, output logic [W-1:0] e);
        int          lat;
        bit          src, lu, bc, stl, hld, fl, pcw;
        logic [1:0]  st;
        logic [31:0] ecnt;
        lat = (d == 0) ? 1 : 3;
        if (!rst) begin
            stall_left[d]  = 0;
            busy_prev[d]   = 0;
            held_cycles[d] = '0;
            e = {2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0};
        end else begin
            st  = busy_prev[d] ? 2'd2 : ((stall_left[d] > 0) ? 2'd1 : 2'd0);
            src = (id_rs_use && ex_rd == id_rs) || (id_rt_use && ex_rd == id_rt);
            lu  = ex_memread && ex_rd != '0 && src;
            bc  = id_branch && ex_regwrite && !ex_memread && ex_rd != '0 && src;
            stl = 0; hld = 0; fl = 0;
            if (mem_busy) hld = 1;
            else if (stall_left[d] > 0) begin stl = 1; stall_left[d]--; end
            else if (lu) begin stl = 1; stall_left[d] = id_branch ? lat : lat - 1; end
            else if (bc) stl = 1;
            else fl = id_jump || (id_branch && id_taken);
            pcw = !(stl || hld);
`ifdef HAZ_STALL_CNT_EN
            ecnt = held_cycles[d];
`else
            ecnt = '0;
`endif
            e = {fsel(ex_rs), fsel(ex_rt), pcw, pcw, fl, stl, hld, st, ecnt};
            if (!pcw && held_cycles[d] != 32'hFFFF_FFFF) held_cycles[d]++;
            busy_prev[d] = mem_busy;
        end
    endtask

    // Driver tasks.
    task automatic push_expect();
        logic [W-1:0] e;
        model_step(0, e); exp_q0.push_back(e);
        model_step(1, e); exp_q1.push_back(e);
    endtask

    task automatic step();
        push_expect();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_rs_use = 0; id_rt_use = 0;
        id_branch = 0; id_taken = 0; id_jump = 0;
        ex_rd = '0; ex_regwrite = 0; ex_memread = 0; ex_rs = '0; ex_rt = '0;
        fwd_rd = '0; fwd_we = '0; mem_busy = 0;
    endtask

    // A reset pulse that starts and ends between two rising edges.
    task automatic rst_pulse();
        idle();
        rst = 0;
        push_expect();
        @(negedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] ra();
        return AW'($urandom_range(0, 3));
    endfunction

    task automatic rand_inputs();
        id_rs = ra(); id_rt = ra();
        id_rs_use = 1'($urandom_range(0, 1)); id_rt_use = 1'($urandom_range(0, 1));
        id_branch = ($urandom_range(0, 2) == 0); id_taken = 1'($urandom_range(0, 1));
        id_jump = ($urandom_range(0, 7) == 0);
        ex_rd = ra(); ex_regwrite = 1'($urandom_range(0, 1));
        ex_memread = ($urandom_range(0, 2) == 0);
        ex_rs = ra(); ex_rt = ra();
        fwd_rd = {ra(), ra()}; fwd_we = 2'($urandom_range(0, 3));
        mem_busy = ($urandom_range(0, 7) == 0);
    endtask

    // Scoreboard monitor: compares each instance at the falling edge, away from the active edge.
    initial begin
        logic [W-1:0] e, a;
        logic [31:0]  acnt;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if ((d == 0 ? exp_q0.size() : exp_q1.size()) > 0) begin
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
`ifdef HAZ_STALL_CNT_EN
                    acnt = stall_cnt[d];
`else
                    acnt = '0;
`endif
                    a = {fwd_a[d], fwd_b[d], pc_write[d], ifid_write[d], ifid_flush[d],
                         idex_bubble[d], pipe_hold[d], state[d], acnt};
                    checks++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL outputs lat=%0d cycle=%0d actual=%h required=%h (fa,fb,pcw,ifw,flush,bub,hold,state,cnt)",
                                 (d == 0) ? 1 : 3, cyc, a, e);
                    end
                end
            end
        end
    end

    // Stimulus: reset, directed scenarios, then random traffic.
    initial begin
        rst = 0;
        idle();
        @(posedge clk);
        #1;
        step();
        // Hazard inputs during reset must not disturb the reset outputs.
        ex_memread = 1; ex_rd = 5'd2; id_rs = 5'd2; id_rs_use = 1; mem_busy = 1;
        fwd_we = 2'b11; fwd_rd = {5'd3, 5'd3}; ex_rs = 5'd3;
        step();
        idle();
        rst = 1;
        step();

        // lw $2 ; add $3,$2,$4
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd2;
        id_rs = 5'd2; id_rt = 5'd4; id_rs_use = 1; id_rt_use = 1;
        step();
        ex_memread = 0; ex_regwrite = 0; ex_rd = '0;
        step();
        idle(); ex_rs = 5'd2; ex_rt = 5'd4; fwd_rd = {5'd2, 5'd0}; fwd_we = 2'b10;
        step();
        idle(); repeat (4) step();

        // add $5,$1,$1 ; beq $5,$0 (taken)
        ex_regwrite = 1; ex_rd = 5'd5;
        id_branch = 1; id_taken = 1; id_rs = 5'd5; id_rt = 5'd0; id_rs_use = 1; id_rt_use = 1;
        step();
        ex_regwrite = 0; ex_rd = '0; fwd_rd = {5'd0, 5'd5}; fwd_we = 2'b01;
        step();
        idle(); repeat (4) step();

        // Forwarding priority and the $0 case.
        fwd_rd = {5'd7, 5'd7}; fwd_we = 2'b11; ex_rs = 5'd7; ex_rt = 5'd7;
        step();
        fwd_rd = '0; ex_rs = '0; ex_rt = '0;
        step();
        idle(); step();

        // lw $3 ; beq $3 : a load feeding an ID-stage compare.
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd3;
        id_branch = 1; id_taken = 1; id_rs = 5'd3; id_rs_use = 1;
        step();
        ex_memread = 0; ex_regwrite = 0; ex_rd = '0;
        repeat (6) step();
        idle(); step();

        // Memory wait landing in the middle of a load-use stall.
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd3; id_rs = 5'd3; id_rs_use = 1;
        step();
        idle(); mem_busy = 1;
        repeat (5) step();
        mem_busy = 0;
        repeat (5) step();

        // Asynchronous reset while the LOAD_LAT=3 instance is in STALL.
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd3; id_branch = 1; id_rs = 5'd3; id_rs_use = 1;
        step();
        idle(); step();
        rst_pulse();
        repeat (3) step();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) rst_pulse();
            else begin
                rand_inputs();
                step();
            end
        end
        idle(); repeat (4) step();

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL drain: pending expectations actual=%0d required=0", exp_q0.size() + exp_q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
